// File: rtl/edge_pulse_gen.sv
// Programmable pulse-train generator: N high pulses of H cycles separated by L-cycle lows,
// with registered rise/fall/done strobes for downstream edge-detection logic.
module edge_pulse_gen #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [LEN_W-1:0] high_len_i,
    input  logic [LEN_W-1:0] low_len_i,
    input  logic [CNT_W-1:0] num_pulses_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             pulse_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [LEN_W-1:0] phase_cnt_reg;
    logic [LEN_W-1:0] high_len_reg;
    logic [LEN_W-1:0] low_len_reg;
    logic [CNT_W-1:0] pulses_left_reg;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // A zero length would stall the phase counter, so it is promoted to one cycle.
    function automatic logic [LEN_W-1:0] nonzero_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_ONE : len;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            phase_cnt_reg   <= '0;
            high_len_reg    <= '0;
            low_len_reg     <= '0;
            pulses_left_reg <= '0;
            busy_o          <= 1'b0;
            pulse_o         <= 1'b0;
            rise_o          <= 1'b0;
            fall_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        high_len_reg <= nonzero_len(high_len_i);
                        low_len_reg  <= nonzero_len(low_len_i);
                        if (num_pulses_i != '0) begin
                            state_reg       <= HIGH;
                            phase_cnt_reg   <= nonzero_len(high_len_i);
                            pulses_left_reg <= num_pulses_i;
                            pulse_o         <= 1'b1;
                            busy_o          <= 1'b1;
                            rise_o          <= 1'b1;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (abort_i) begin
                        state_reg <= IDLE;
                        pulse_o   <= 1'b0;
                        busy_o    <= 1'b0;
                        fall_o    <= 1'b1;
                        done_o    <= 1'b1;
                    end else if (phase_cnt_reg == LEN_ONE) begin
                        pulse_o <= 1'b0;
                        fall_o  <= 1'b1;
                        // The last pulse ends the train directly, with no trailing low phase.
                        if (pulses_left_reg == CNT_ONE) begin
                            state_reg <= IDLE;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                        end else begin
                            state_reg       <= LOW;
                            phase_cnt_reg   <= low_len_reg;
                            pulses_left_reg <= pulses_left_reg - CNT_ONE;
                        end
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - LEN_ONE;
                    end
                end
                LOW: begin
                    if (abort_i) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                    end else if (phase_cnt_reg == LEN_ONE) begin
                        state_reg     <= HIGH;
                        phase_cnt_reg <= high_len_reg;
                        pulse_o       <= 1'b1;
                        rise_o        <= 1'b1;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - LEN_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    pulse_o   <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: vector table plus hand sequences for reset and edge-detector loopback.
module tb_edge_pulse_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [7:0] high_len_i;
    logic [7:0] low_len_i;
    logic [7:0] num_pulses_i;
    logic       abort_i;
    logic       busy_o, pulse_o, rise_o, fall_o, done_o;

    int checks = 0;
    int errors = 0;

    edge_pulse_gen #(.LEN_W(8), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .high_len_i   (high_len_i),
        .low_len_i    (low_len_i),
        .num_pulses_i (num_pulses_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .pulse_o      (pulse_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Registered edge detector with active-high reset, fed by pulse_o.
    logic det_prev, det_rise, det_fall;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            det_prev <= 1'b0;
            det_rise <= 1'b0;
            det_fall <= 1'b0;
        end else begin
            det_prev <= pulse_o;
            det_rise <= pulse_o & ~det_prev;
            det_fall <= ~pulse_o & det_prev;
        end
    end

    // exp bits: {pulse, rise, fall, done, busy}
    typedef struct {
        string      tag;
        logic       start;
        logic       abort;
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] n;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string tag, input logic s, input logic a,
                                input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                                input logic [4:0] exp);
        vec_t v;
        v.tag = tag; v.start = s; v.abort = a; v.h = h; v.l = l; v.n = n; v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic logic [4:0] outs();
        return {pulse_o, rise_o, fall_o, done_o, busy_o};
    endfunction

    task automatic check_outs(input string tag, input logic [4:0] exp);
        logic [4:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {pulse,rise,fall,done,busy} got %b expected %b", tag, act, exp);
        end else begin
            $display("ok   %s: {pulse,rise,fall,done,busy}=%b", tag, act);
        end
    endtask

    task automatic check_int(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("ok   %s: %0d", tag, act);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic [7:0] h,
                        input logic [7:0] l, input logic [7:0] n);
        start_i = s; abort_i = a; high_len_i = h; low_len_i = l; num_pulses_i = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rise_q[$], fall_q[$], drise_q[$], dfall_q[$];
        int busy_cnt, done_cnt, cyc;
        bit seen_done;

        reset = 1'b1; start_i = 0; abort_i = 0; high_len_i = 0; low_len_i = 0; num_pulses_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_state", 5'b00000);
        @(negedge clk);
        reset = 1'b0;

        // Basic train H=3 L=2 N=2
        add("basic_t1", 1, 0, 3, 2, 2, 5'b11001);
        add("basic_t2", 0, 0, 0, 0, 0, 5'b10001);
        add("basic_t3", 0, 0, 0, 0, 0, 5'b10001);
        add("basic_t4", 0, 0, 0, 0, 0, 5'b00101);
        add("basic_t5", 0, 0, 0, 0, 0, 5'b00001);
        add("basic_t6", 0, 0, 0, 0, 0, 5'b11001);
        add("basic_t7", 0, 0, 0, 0, 0, 5'b10001);
        add("basic_t8", 0, 0, 0, 0, 0, 5'b10001);
        add("basic_t9", 0, 0, 0, 0, 0, 5'b00110);
        add("basic_idle", 0, 0, 0, 0, 0, 5'b00000);
        // Zero count and zero lengths
        add("n0_done", 1, 0, 4, 4, 0, 5'b00010);
        add("n0_idle", 0, 0, 0, 0, 0, 5'b00000);
        add("h0l0_t1", 1, 0, 0, 0, 2, 5'b11001);
        add("h0l0_t2", 0, 0, 0, 0, 0, 5'b00101);
        add("h0l0_t3", 0, 0, 0, 0, 0, 5'b11001);
        add("h0l0_t4", 0, 0, 0, 0, 0, 5'b00110);
        add("h0l0_idle", 0, 0, 0, 0, 0, 5'b00000);
        // Abort during LOW, then during HIGH, then in IDLE
        add("abl_t1", 1, 0, 2, 3, 2, 5'b11001);
        add("abl_t2", 0, 0, 0, 0, 0, 5'b10001);
        add("abl_t3", 0, 0, 0, 0, 0, 5'b00101);
        add("abl_abort", 0, 1, 0, 0, 0, 5'b00010);
        add("abl_idle", 0, 0, 0, 0, 0, 5'b00000);
        add("abh_t1", 1, 0, 4, 1, 3, 5'b11001);
        add("abh_abort", 0, 1, 0, 0, 0, 5'b00110);
        add("abh_idle", 0, 0, 0, 0, 0, 5'b00000);
        add("idle_abort_start", 1, 1, 3, 3, 3, 5'b00000);
        add("idle_abort_only", 0, 1, 3, 3, 3, 5'b00000);
        add("idle_quiet", 0, 0, 0, 0, 0, 5'b00000);
        // Busy lockout: second start with new settings is ignored
        add("lock_t1", 1, 0, 2, 1, 2, 5'b11001);
        add("lock_restart", 1, 0, 7, 7, 9, 5'b10001);
        add("lock_t3", 0, 0, 0, 0, 0, 5'b00101);
        add("lock_t4", 0, 0, 0, 0, 0, 5'b11001);
        add("lock_t5", 0, 0, 0, 0, 0, 5'b10001);
        add("lock_t6", 0, 0, 0, 0, 0, 5'b00110);
        // Back-to-back trains of one single-cycle pulse
        add("b2b_a1", 1, 0, 1, 1, 1, 5'b11001);
        add("b2b_a2", 0, 0, 0, 0, 0, 5'b00110);
        add("b2b_b1", 1, 0, 1, 1, 1, 5'b11001);
        add("b2b_b2", 0, 0, 0, 0, 0, 5'b00110);
        add("b2b_idle", 0, 0, 0, 0, 0, 5'b00000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].abort, vecs[i].h, vecs[i].l, vecs[i].n);
            check_outs(vecs[i].tag, vecs[i].exp);
        end

        // Reset in cycle 2 of HIGH (H=5, N=3): outputs drop at once, no fall, no done.
        step(1, 0, 5, 5, 3);
        check_outs("rst_mid_t1", 5'b11001);
        step(0, 0, 0, 0, 0);
        check_outs("rst_mid_t2", 5'b10001);
        #2 reset = 1'b1;
        #1;
        check_outs("rst_mid_async", 5'b00000);
        @(posedge clk);
        #1;
        check_outs("rst_mid_hold", 5'b00000);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 0, 0);
        check_outs("rst_mid_after", 5'b00000);

        // Loopback into the edge detector: H=4 L=4 N=5
        busy_cnt = 0; done_cnt = 0; seen_done = 0;
        step(1, 0, 4, 4, 5);
        cyc = 0;
        for (int k = 0; k < 200; k++) begin
            if (rise_o)   rise_q.push_back(cyc);
            if (fall_o)   fall_q.push_back(cyc);
            if (det_rise) drise_q.push_back(cyc);
            if (det_fall) dfall_q.push_back(cyc);
            if (busy_o)   busy_cnt++;
            if (done_o)   done_cnt++;
            if (seen_done) break;
            if (done_o) seen_done = 1;
            step(0, 0, 0, 0, 0);
            cyc++;
        end
        check_int("loop_done_seen", int'(seen_done), 1);
        check_int("loop_done_count", done_cnt, 1);
        check_int("loop_busy_cycles", busy_cnt, 36);
        check_int("loop_rise_o_count", rise_q.size(), 5);
        check_int("loop_fall_o_count", fall_q.size(), 5);
        check_int("loop_det_rise_count", drise_q.size(), 5);
        check_int("loop_det_fall_count", dfall_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rise_q.size())
                check_int($sformatf("loop_rise_cycle_%0d", i), rise_q[i], 8 * i);
            if (i < fall_q.size())
                check_int($sformatf("loop_fall_cycle_%0d", i), fall_q[i], 8 * i + 4);
            if (i < rise_q.size() && i < drise_q.size())
                check_int($sformatf("loop_rise_lag_%0d", i), drise_q[i] - rise_q[i], 1);
            if (i < fall_q.size() && i < dfall_q.size())
                check_int($sformatf("loop_fall_lag_%0d", i), dfall_q[i] - fall_q[i], 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
